// File: rtl/mem_access.sv
// Memory access stage: turns a load/store from execute into a single-strobe
// request/ready transaction. The pipeline is stalled while the access is in flight.
// Misaligned, conflicting or timed-out accesses latch a sticky error.
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] Addr,
    input  logic [15:0] WrData,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] MemOut,
    output logic        Stall,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] mem_out_q, mem_out_d;
    logic        err_q, err_d;

    logic        access;
    logic        fault;
    logic [8:0]  cnt_inc;
    logic        timed_out;

    assign access    = MemRead | MemWrite;
    assign fault     = (MemRead & MemWrite) | (access & Addr[0]);
    // Cycle number of the current REQ/WAIT cycle (1-based).
    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    assign timed_out = (cnt_inc >= 9'(TIMEOUT));

    // Next-state, request latching, load capture and the combinational stall.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_out_d   = mem_out_q;
        err_d       = err_q;
        Stall       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fault) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    Stall   = 1'b1;
                end else if (access) begin
                    state_d     = StReq;
                    mem_en_d    = 1'b1;  // strobe is high for exactly the REQ cycle
                    mem_wr_d    = MemWrite;
                    mem_addr_d  = Addr;
                    mem_wdata_d = WrData;
                    cnt_d       = 8'd0;
                    Stall       = 1'b1;
                end
            end
            StReq, StWait: begin
                Stall = 1'b1;
                cnt_d = cnt_inc[7:0];
                if (mem_ready) begin
                    state_d = StDone;
                    if (!mem_wr_q) begin
                        mem_out_d = mem_rdata;
                    end
                end else if (state_q == StReq) begin
                    state_d = StWait;
                end else if (timed_out) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                // One free cycle lets the pipeline advance past this instruction.
                state_d = StIdle;
            end
            StErr: begin
                Stall = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 16'd0;
            mem_out_q   <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_out_q   <= mem_out_d;
            err_q       <= err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign MemOut    = mem_out_q;
    assign err       = err_q;

endmodule
